// File: rtl/riscv_hazard_scoreboard.sv
// riscv_hazard_scoreboard: in-flight write tracking, youngest-producer operand forwarding and load-use stall.
// Optional feature macro HAZARD_PERF_CNT_EN adds stall-cycle and forwarding-event counters.
module riscv_hazard_scoreboard #(
   parameter int NUM_SRC        = 2,
   parameter int DEPTH          = 3,
   parameter int LOAD_READY_IDX = 1,
   parameter int XLEN           = 32
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               id_valid,
   input  logic                               id_we,
   input  logic                               id_is_load,
   input  logic [4:0]                         id_rd,
   input  logic [NUM_SRC*5-1:0]               id_src,
   input  logic [NUM_SRC*XLEN-1:0]            rf_data,
   input  logic [DEPTH*XLEN-1:0]              stage_data,
   input  logic                               flush,
   output logic                               stall,
   output logic [NUM_SRC*$clog2(DEPTH+1)-1:0] fwd_sel,
   output logic [NUM_SRC*XLEN-1:0]            operand
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0]                        perf_stall_cycles,
   output logic [31:0]                        perf_fwd_events
`endif
);
   localparam int SW = $clog2(DEPTH+1);
   logic [DEPTH-1:0]   ent_v;
   logic [DEPTH-1:0]   ent_ld;
   logic [4:0]         ent_rd [DEPTH];
   logic [NUM_SRC-1:0] hazard;
   // Scan oldest to youngest so the youngest matching producer overwrites the others.
   always_comb begin
      fwd_sel = '0;
      operand = rf_data;
      hazard  = '0;
      for (int j = 0; j < NUM_SRC; j++)
         for (int i = DEPTH-1; i >= 0; i--)
            if (ent_v[i] && id_src[j*5 +: 5] != 5'd0 && ent_rd[i] == id_src[j*5 +: 5]) begin
               fwd_sel[j*SW +: SW]     = SW'(i+1);
               operand[j*XLEN +: XLEN] = stage_data[i*XLEN +: XLEN];
               hazard[j]               = ent_ld[i] && i < LOAD_READY_IDX;
            end
   end
   assign stall = id_valid & |hazard & ~flush;
   always_ff @(posedge clk)
      if (!rst_n) begin
         ent_v  <= '0;
         ent_ld <= '0;
      end else begin
         for (int i = DEPTH-1; i > 0; i--) begin
            ent_v[i]  <= ent_v[i-1];
            ent_ld[i] <= ent_ld[i-1];
            ent_rd[i] <= ent_rd[i-1];
         end
         ent_v[0]  <= id_valid & id_we & (id_rd != 5'd0) & ~stall & ~flush;
         ent_ld[0] <= id_is_load;
         ent_rd[0] <= id_rd;
      end
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] fwd_cnt;
   always_comb begin
      fwd_cnt = '0;
      for (int j = 0; j < NUM_SRC; j++)
         fwd_cnt = fwd_cnt + 32'(fwd_sel[j*SW +: SW] != '0);
   end
   always_ff @(posedge clk)
      if (!rst_n) begin
         perf_stall_cycles <= '0;
         perf_fwd_events   <= '0;
      end else begin
         perf_stall_cycles <= perf_stall_cycles + 32'(stall);
         if (id_valid && !stall)
            perf_fwd_events <= perf_fwd_events + fwd_cnt;
      end
`endif
endmodule

// File: tb/tb_riscv_hazard_scoreboard.sv
// tb_riscv_hazard_scoreboard: default-config DUT plus a DEPTH=5/NUM_SRC=3/LOAD_READY_IDX=2 DUT,
// checked against a queue-based history of issued instructions.
module tb_riscv_hazard_scoreboard;
   logic clk = 0, rst_n = 0;
   always #5 clk = ~clk;
   int vectors = 0, miscompares = 0;

   logic va = 0, wea = 0, lda = 0, fla = 0, stalla;
   logic [4:0] rda = 0;
   logic [9:0] srca = 0;
   logic [63:0] rfa = 0, opa;
   logic [95:0] sda = 0;
   logic [3:0] sela;

   logic vb = 0, web = 0, ldb = 0, flb = 0, stallb;
   logic [4:0] rdb = 0;
   logic [14:0] srcb = 0;
   logic [95:0] rfb = 0, opb;
   logic [159:0] sdb = 0;
   logic [8:0] selb;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] psa, pfa, psb, pfb, m_ps = 0, m_pf = 0;
`endif

   riscv_hazard_scoreboard dut_a (
      .clk(clk), .rst_n(rst_n), .id_valid(va), .id_we(wea), .id_is_load(lda), .id_rd(rda),
      .id_src(srca), .rf_data(rfa), .stage_data(sda), .flush(fla), .stall(stalla),
      .fwd_sel(sela), .operand(opa)
`ifdef HAZARD_PERF_CNT_EN
      , .perf_stall_cycles(psa), .perf_fwd_events(pfa)
`endif
   );

   riscv_hazard_scoreboard #(.NUM_SRC(3), .DEPTH(5), .LOAD_READY_IDX(2), .XLEN(32)) dut_b (
      .clk(clk), .rst_n(rst_n), .id_valid(vb), .id_we(web), .id_is_load(ldb), .id_rd(rdb),
      .id_src(srcb), .rf_data(rfb), .stage_data(sdb), .flush(flb), .stall(stallb),
      .fwd_sel(selb), .operand(opb)
`ifdef HAZARD_PERF_CNT_EN
      , .perf_stall_cycles(psb), .perf_fwd_events(pfb)
`endif
   );

   // Reference: queue of the last DEPTH issued instructions, youngest first.
   typedef struct packed {logic v; logic [4:0] rd; logic ld;} ent_t;
   ent_t qa[$], qb[$];

   function automatic int msel(ent_t q[$], logic [4:0] s);
      for (int i = 0; i < q.size(); i++)
         if (s != 0 && q[i].v && q[i].rd == s) return i + 1;
      return 0;
   endfunction

   function automatic logic mhz(ent_t q[$], logic [4:0] s, int lri);
      int k = msel(q, s);
      return k != 0 && q[k-1].ld && (k - 1) < lri;
   endfunction

   function automatic logic exp_stall_a();
      return va & ~fla & (mhz(qa, srca[4:0], 1) | mhz(qa, srca[9:5], 1));
   endfunction

   function automatic logic exp_stall_b();
      return vb & ~flb & (mhz(qb, srcb[4:0], 2) | mhz(qb, srcb[9:5], 2) | mhz(qb, srcb[14:10], 2));
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         qa.delete();
         qb.delete();
         repeat (3) qa.push_back('0);
         repeat (5) qb.push_back('0);
`ifdef HAZARD_PERF_CNT_EN
         m_ps <= 0;
         m_pf <= 0;
`endif
      end else begin
`ifdef HAZARD_PERF_CNT_EN
         m_ps <= m_ps + 32'(exp_stall_a());
         if (va && !exp_stall_a())
            m_pf <= m_pf + 32'(int'(msel(qa, srca[4:0]) != 0) + int'(msel(qa, srca[9:5]) != 0));
`endif
         qa.push_front(ent_t'({va & wea & (rda != 0) & ~exp_stall_a() & ~fla, rda, lda}));
         qb.push_front(ent_t'({vb & web & (rdb != 0) & ~exp_stall_b() & ~flb, rdb, ldb}));
         void'(qa.pop_back());
         void'(qb.pop_back());
      end
   end

   task automatic drv_a(input logic v, we, ld, input logic [4:0] rd, s0, s1, input logic fl);
      @(negedge clk);
      va = v; wea = we; lda = ld; rda = rd; srca = {s1, s0}; fla = fl;
      rfa = {s1 == 0 ? 32'd0 : $urandom, s0 == 0 ? 32'd0 : $urandom};
      sda = {$urandom, $urandom, $urandom};
      #1;
   endtask

   task automatic drv_b(input logic v, we, ld, input logic [4:0] rd, s0, s1, s2, input logic fl);
      @(negedge clk);
      vb = v; web = we; ldb = ld; rdb = rd; srcb = {s2, s1, s0}; flb = fl;
      rfb = {s2 == 0 ? 32'd0 : $urandom, s1 == 0 ? 32'd0 : $urandom, s0 == 0 ? 32'd0 : $urandom};
      sdb = {$urandom, $urandom, $urandom, $urandom, $urandom};
      #1;
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      drv_a(1, 1, 1, 5'd1, 5'd1, 5'd2, 0);
      drv_b(1, 1, 1, 5'd1, 5'd1, 5'd2, 5'd3, 0);
      vectors++; if (stalla !== 1'b0) begin miscompares++; $display("FAIL reset_stall_a got=%0h exp=0", stalla); end
      vectors++; if (sela !== 4'd0) begin miscompares++; $display("FAIL reset_sel_a got=%0h exp=0", sela); end
      vectors++; if (opa !== rfa) begin miscompares++; $display("FAIL reset_op_a got=%0h exp=%0h", opa, rfa); end
      vectors++; if (selb !== 9'd0 || stallb !== 1'b0) begin miscompares++; $display("FAIL reset_b sel=%0h stall=%0h exp=0/0", selb, stallb); end
      rst_n = 1;
      drv_b(0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 0);
   endtask

   task automatic test_back_to_back;
      drv_a(1, 1, 0, 5'd1, 5'd0, 5'd0, 0);
      drv_a(1, 1, 0, 5'd2, 5'd0, 5'd0, 0);
      drv_a(1, 1, 0, 5'd3, 5'd1, 5'd2, 0);
      vectors++; if (sela !== 4'b0110) begin miscompares++; $display("FAIL chain_x3_sel got=%0h exp=6", sela); end
      vectors++; if (opa !== {sda[31:0], sda[63:32]}) begin miscompares++; $display("FAIL chain_x3_op got=%0h exp=%0h", opa, {sda[31:0], sda[63:32]}); end
      vectors++; if (stalla !== 1'b0) begin miscompares++; $display("FAIL chain_x3_stall got=%0h exp=0", stalla); end
      drv_a(1, 1, 0, 5'd4, 5'd3, 5'd1, 0);
      vectors++; if (sela !== 4'b1101) begin miscompares++; $display("FAIL chain_x4_sel got=%0h exp=d", sela); end
      drv_a(1, 1, 0, 5'd5, 5'd4, 5'd2, 0);
      vectors++; if (sela !== 4'b1101 || stalla !== 1'b0) begin miscompares++; $display("FAIL chain_x5 sel=%0h stall=%0h exp=d/0", sela, stalla); end
   endtask

   task automatic test_load_use;
      drv_a(1, 1, 1, 5'd10, 5'd0, 5'd0, 0);
      drv_a(1, 1, 0, 5'd11, 5'd10, 5'd1, 0);
      vectors++; if (stalla !== 1'b1) begin miscompares++; $display("FAIL loaduse_stall got=%0h exp=1", stalla); end
      vectors++; if (sela[1:0] !== 2'd1) begin miscompares++; $display("FAIL loaduse_sel_ex got=%0h exp=1", sela[1:0]); end
      drv_a(1, 1, 0, 5'd11, 5'd10, 5'd1, 0);
      vectors++; if (stalla !== 1'b0) begin miscompares++; $display("FAIL loaduse_release got=%0h exp=0", stalla); end
      vectors++; if (sela[1:0] !== 2'd2 || opa[31:0] !== sda[63:32]) begin miscompares++; $display("FAIL loaduse_mem sel=%0h op=%0h exp=2/%0h", sela[1:0], opa[31:0], sda[63:32]); end
   endtask

   task automatic test_same_rd;
      drv_a(1, 1, 0, 5'd3, 5'd0, 5'd0, 0);
      drv_a(1, 1, 0, 5'd3, 5'd0, 5'd0, 0);
      drv_a(1, 1, 0, 5'd12, 5'd3, 5'd3, 0);
      vectors++; if (sela !== 4'b0101) begin miscompares++; $display("FAIL same_rd_sel got=%0h exp=5", sela); end
      vectors++; if (opa !== {sda[31:0], sda[31:0]}) begin miscompares++; $display("FAIL same_rd_op got=%0h exp=%0h", opa, {sda[31:0], sda[31:0]}); end
   endtask

   task automatic test_x0;
      drv_a(1, 1, 0, 5'd0, 5'd0, 5'd0, 0);
      drv_a(1, 1, 1, 5'd0, 5'd0, 5'd0, 0);
      drv_a(1, 1, 0, 5'd13, 5'd0, 5'd0, 0);
      vectors++; if (sela !== 4'd0 || opa !== 64'd0 || stalla !== 1'b0) begin miscompares++; $display("FAIL x0 sel=%0h op=%0h stall=%0h exp=0/0/0", sela, opa, stalla); end
   endtask

   task automatic test_flush;
      drv_a(1, 1, 1, 5'd14, 5'd0, 5'd0, 0);
      drv_a(1, 1, 0, 5'd15, 5'd14, 5'd0, 1);
      vectors++; if (stalla !== 1'b0) begin miscompares++; $display("FAIL flush_wins got=%0h exp=0", stalla); end
      drv_a(1, 1, 0, 5'd16, 5'd15, 5'd14, 0);
      vectors++; if (sela !== 4'b1000) begin miscompares++; $display("FAIL flush_bubble_sel got=%0h exp=8", sela); end
      vectors++; if (stalla !== 1'b0) begin miscompares++; $display("FAIL flush_after_stall got=%0h exp=0", stalla); end
   endtask

   task automatic test_reset_mid;
      drv_a(1, 1, 0, 5'd17, 5'd0, 5'd0, 0);
      drv_a(1, 1, 1, 5'd19, 5'd0, 5'd0, 0);
      drv_a(1, 1, 0, 5'd20, 5'd19, 5'd17, 0);
      vectors++; if (stalla !== 1'b1) begin miscompares++; $display("FAIL rstmid_pre_stall got=%0h exp=1", stalla); end
      rst_n = 0;
      drv_a(1, 1, 0, 5'd20, 5'd19, 5'd17, 0);
      rst_n = 1;
      vectors++; if (sela !== 4'd0 || stalla !== 1'b0) begin miscompares++; $display("FAIL rstmid sel=%0h stall=%0h exp=0/0", sela, stalla); end
   endtask

   task automatic test_random_a;
      for (int n = 0; n < 400; n++) begin
         logic [4:0] s [2];
         int e;
         s[0] = 5'($urandom_range(0, 7));
         s[1] = 5'($urandom_range(0, 7));
         drv_a($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
               5'($urandom_range(0, 7)), s[0], s[1], $urandom_range(0, 9) == 0);
         for (int j = 0; j < 2; j++) begin
            e = msel(qa, s[j]);
            vectors++; if (sela[j*2 +: 2] !== 2'(e)) begin miscompares++; $display("FAIL rand_a_sel%0d got=%0d exp=%0d", j, sela[j*2 +: 2], e); end
            vectors++; if (opa[j*32 +: 32] !== (e == 0 ? rfa[j*32 +: 32] : sda[(e-1)*32 +: 32])) begin miscompares++; $display("FAIL rand_a_op%0d got=%0h sel=%0d", j, opa[j*32 +: 32], e); end
         end
         vectors++; if (stalla !== exp_stall_a()) begin miscompares++; $display("FAIL rand_a_stall got=%0h exp=%0h", stalla, exp_stall_a()); end
      end
      drv_a(0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
   endtask

   task automatic test_deep;
      int stalls = 0;
`ifdef HAZARD_PERF_CNT_EN
      logic [31:0] ps0 = psb;
`endif
      drv_b(1, 1, 1, 5'd9, 5'd0, 5'd0, 5'd0, 0);
      for (int k = 0; k < 6; k++) begin
         drv_b(1, 1, 0, 5'd10, 5'd9, 5'd0, 5'd0, 0);
         if (stallb !== 1'b1) break;
         stalls++;
      end
      vectors++; if (stalls != 2) begin miscompares++; $display("FAIL deep_stall_cycles got=%0d exp=2", stalls); end
      vectors++; if (selb[2:0] !== 3'd3 || opb[31:0] !== sdb[95:64]) begin miscompares++; $display("FAIL deep_sel sel=%0d op=%0h exp=3/%0h", selb[2:0], opb[31:0], sdb[95:64]); end
      drv_b(0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 0);
`ifdef HAZARD_PERF_CNT_EN
      vectors++; if (psb - ps0 !== 32'd2) begin miscompares++; $display("FAIL deep_perf_stall got=%0d exp=2", psb - ps0); end
`endif
   endtask

   task automatic test_random_b;
      for (int n = 0; n < 250; n++) begin
         logic [4:0] s [3];
         int e;
         for (int j = 0; j < 3; j++) s[j] = 5'($urandom_range(0, 7));
         drv_b($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
               5'($urandom_range(0, 7)), s[0], s[1], s[2], $urandom_range(0, 9) == 0);
         for (int j = 0; j < 3; j++) begin
            e = msel(qb, s[j]);
            vectors++; if (selb[j*3 +: 3] !== 3'(e)) begin miscompares++; $display("FAIL rand_b_sel%0d got=%0d exp=%0d", j, selb[j*3 +: 3], e); end
            vectors++; if (opb[j*32 +: 32] !== (e == 0 ? rfb[j*32 +: 32] : sdb[(e-1)*32 +: 32])) begin miscompares++; $display("FAIL rand_b_op%0d got=%0h sel=%0d", j, opb[j*32 +: 32], e); end
         end
         vectors++; if (stallb !== exp_stall_b()) begin miscompares++; $display("FAIL rand_b_stall got=%0h exp=%0h", stallb, exp_stall_b()); end
      end
      drv_b(0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 0);
   endtask

   initial begin
      test_reset;
      test_back_to_back;
      test_load_use;
      test_same_rd;
      test_x0;
      test_flush;
      test_reset_mid;
      test_random_a;
      test_deep;
      test_random_b;
`ifdef HAZARD_PERF_CNT_EN
      vectors++; if (psa !== m_ps || pfa !== m_pf) begin miscompares++; $display("FAIL perf_a stall=%0d fwd=%0d exp=%0d/%0d", psa, pfa, m_ps, m_pf); end
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
